// File: rtl/stream_pack_pkg.sv
// Shared pipeline package: default beat geometry and lane-index sizing for the
// packing stage.
package stream_pack_pkg;

    localparam int DEFAULT_IN_W  = 32;
    localparam int DEFAULT_RATIO = 8;

    // Width of a counter that indexes lanes 0..ratio-1 (never narrower than 1 bit).
    function automatic int lane_idx_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/stream_pack.sv
// Packs RATIO narrow input beats into one wide word; f_last_in flushes a partial word.
// Optional STREAM_PACK_KEEP_EN adds b_keep_out, a per-lane valid mask registered with the word.
module stream_pack
    import stream_pack_pkg::*;
#(
    parameter int IN_W   = DEFAULT_IN_W,
    parameter int RATIO  = DEFAULT_RATIO,
    parameter int DATA_W = IN_W * RATIO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_valid_in,
    input  logic [IN_W-1:0]   f_data_in,
    input  logic              f_last_in,
    output logic              f_ready_out,
    output logic              b_valid_out,
    output logic [DATA_W-1:0] b_data_out,
    output logic              b_last_out,
`ifdef STREAM_PACK_KEEP_EN
    output logic [RATIO-1:0]  b_keep_out,
`endif
    input  logic              b_ready_in
);

    localparam int               CNT_W     = lane_idx_w(RATIO);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    if (DATA_W != IN_W * RATIO) begin : g_bad_data_w
        $error("stream_pack: DATA_W must equal IN_W*RATIO");
    end
    if (RATIO < 2) begin : g_bad_ratio
        $error("stream_pack: RATIO must be at least 2");
    end

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] asm_reg;
    logic [DATA_W-1:0] word_next;
    logic              accept;
    logic              close;

    assign f_ready_out = !b_valid_out || b_ready_in;
    assign accept      = f_valid_in && f_ready_out;
    assign close       = accept && ((cnt == LAST_LANE) || f_last_in);

    // Assembly contents with the current beat dropped into lane cnt; lanes above it are zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        word_next = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (CNT_W'(i) < cnt) begin
                word_next[i*IN_W +: IN_W] = asm_reg[i*IN_W +: IN_W];
            end else if (CNT_W'(i) == cnt) begin
                word_next[i*IN_W +: IN_W] = f_data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: asm_reg is reset (not just the control bits) so a word that was cut short
        // by reset can never leak old lanes into the next partial word.
        if (rst) begin
            cnt         <= '0;
            asm_reg     <= '0;
            b_valid_out <= 1'b0;
            b_data_out  <= '0;
            b_last_out  <= 1'b0;
        end else begin
            // NOTE: state updates are non-blocking; the later close assignment to
            // b_valid_out overrides the delivery clear when both happen on one edge.
            if (b_valid_out && b_ready_in) begin
                b_valid_out <= 1'b0;
            end
            if (close) begin
                b_data_out  <= word_next;
                b_last_out  <= f_last_in;
                b_valid_out <= 1'b1;
                cnt         <= '0;
                asm_reg     <= '0;
            end else if (accept) begin
                asm_reg <= word_next;
                cnt     <= cnt + 1'b1;
            end
        end
    end

`ifdef STREAM_PACK_KEEP_EN
    logic [RATIO-1:0] keep_next;

    always_comb begin
        keep_next = '0;
        for (int i = 0; i < RATIO; i++) begin
            keep_next[i] = (CNT_W'(i) <= cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_keep_out <= '0;
        end else if (close) begin
            b_keep_out <= keep_next;
        end
    end
`endif

endmodule

// File: tb/tb_stream_pack.sv
// Directed self-checking bench for stream_pack at default geometry (32-bit beats x 8).
module tb_stream_pack;

    logic         clk = 1'b0;
    logic         rst;
    logic         f_valid_in;
    logic [31:0]  f_data_in;
    logic         f_last_in;
    logic         f_ready_out;
    logic         b_valid_out;
    logic [255:0] b_data_out;
    logic         b_last_out;
    logic         b_ready_in;
`ifdef STREAM_PACK_KEEP_EN
    logic [7:0]   b_keep_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    stream_pack dut (
        .clk         (clk),
        .rst         (rst),
        .f_valid_in  (f_valid_in),
        .f_data_in   (f_data_in),
        .f_last_in   (f_last_in),
        .f_ready_out (f_ready_out),
        .b_valid_out (b_valid_out),
        .b_data_out  (b_data_out),
        .b_last_out  (b_last_out),
`ifdef STREAM_PACK_KEEP_EN
        .b_keep_out  (b_keep_out),
`endif
        .b_ready_in  (b_ready_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        f_valid_in = 1'b1;
        f_data_in  = d;
        f_last_in  = l;
        tick();
    endtask

    task automatic idle();
        f_valid_in = 1'b0;
        f_last_in  = 1'b0;
        tick();
    endtask

    // Expected word: n lanes counting up from base, remaining lanes zero.
    function automatic logic [255:0] lanes(input logic [31:0] base, input int n);
        logic [255:0] w = '0;
        for (int i = 0; i < n; i++) w[i*32 +: 32] = base + 32'(i);
        return w;
    endfunction

    initial begin
        rst = 1'b1; f_valid_in = 1'b0; f_data_in = '0; f_last_in = 1'b0; b_ready_in = 1'b0;
        tick();
        tick();
        check("rst_valid", b_valid_out, 0);
        check("rst_data", b_data_out, 0);
        check("rst_last", b_last_out, 0);
`ifdef STREAM_PACK_KEEP_EN
        check("rst_keep", b_keep_out, 0);
`endif
        rst = 1'b0;
        #1;
        check("rst_ready", f_ready_out, 1);

        // Full word 0..7
        b_ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(32'(i), 1'b0);
            if (i < 7) check("full_no_early_valid", b_valid_out, 0);
        end
        check("full_valid", b_valid_out, 1);
        check("full_data", b_data_out,
              256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
        check("full_last", b_last_out, 0);
`ifdef STREAM_PACK_KEEP_EN
        check("full_keep", b_keep_out, 8'hFF);
`endif
        idle();
        check("full_delivered", b_valid_out, 0);

        // Partial flush: 0xA, 0xB(last)
        send(32'hA, 1'b0);
        check("part_no_early_valid", b_valid_out, 0);
        send(32'hB, 1'b1);
        check("part_valid", b_valid_out, 1);
        check("part_data", b_data_out, 256'h0000000B_0000000A);
        check("part_last", b_last_out, 1);
`ifdef STREAM_PACK_KEEP_EN
        check("part_keep", b_keep_out, 8'h03);
`endif
        idle();
        check("part_delivered", b_valid_out, 0);

        // Back-pressure: word pending for 5 cycles while junk beats are offered
        b_ready_in = 1'b0;
        for (int i = 0; i < 8; i++) send(32'h10 + 32'(i), 1'b0);
        check("bp_valid", b_valid_out, 1);
        check("bp_ready_low", f_ready_out, 0);
        for (int s = 0; s < 5; s++) begin
            f_valid_in = 1'b1;
            f_data_in  = 32'hDEAD0000 + 32'(s);
            f_last_in  = 1'b1;
            tick();
            check("bp_stall_ready", f_ready_out, 0);
            check("bp_stall_valid", b_valid_out, 1);
            check("bp_stall_data", b_data_out, lanes(32'h10, 8));
            check("bp_stall_last", b_last_out, 0);
        end
        f_data_in  = 32'h20;
        f_last_in  = 1'b0;
        b_ready_in = 1'b1;
        #1;
        check("bp_release_ready", f_ready_out, 1);
        tick();
        check("bp_delivered", b_valid_out, 0);
        for (int i = 1; i < 8; i++) send(32'h20 + 32'(i), 1'b0);
        check("bp_next_valid", b_valid_out, 1);
        check("bp_next_data", b_data_out, lanes(32'h20, 8));
        idle();
        check("bp_next_delivered", b_valid_out, 0);

        // 16 back-to-back beats, no input bubbles
        for (int i = 0; i < 16; i++) begin
            f_valid_in = 1'b1;
            f_data_in  = 32'h30 + 32'(i);
            f_last_in  = 1'b0;
            #1;
            check("b2b_ready", f_ready_out, 1);
            tick();
            if (i == 7) begin
                check("b2b_w0_valid", b_valid_out, 1);
                check("b2b_w0_data", b_data_out, lanes(32'h30, 8));
            end
            if (i == 8) check("b2b_w0_gone", b_valid_out, 0);
        end
        check("b2b_w1_valid", b_valid_out, 1);
        check("b2b_w1_data", b_data_out, lanes(32'h38, 8));

        // Close and delivery on the same edge: single-beat last words back to back
        for (int i = 0; i < 3; i++) begin
            send(32'h50 + 32'(i), 1'b1);
            check("simul_valid", b_valid_out, 1);
            check("simul_data", b_data_out, 256'(32'h50 + 32'(i)));
            check("simul_last", b_last_out, 1);
        end
        idle();
        check("simul_delivered", b_valid_out, 0);

        // Reset mid-word, with a beat offered during reset
        for (int i = 0; i < 3; i++) send(32'h60 + 32'(i), 1'b0);
        check("rmw_no_valid", b_valid_out, 0);
        f_valid_in = 1'b1;
        f_data_in  = 32'h99;
        f_last_in  = 1'b1;
        rst        = 1'b1;
        tick();
        rst        = 1'b0;
        f_valid_in = 1'b0;
        f_last_in  = 1'b0;
        #1;
        check("rmw_valid", b_valid_out, 0);
        check("rmw_data", b_data_out, 0);
        check("rmw_ready", f_ready_out, 1);
        for (int i = 0; i < 8; i++) send(32'h70 + 32'(i), 1'b0);
        check("rmw_word_valid", b_valid_out, 1);
        check("rmw_word_data", b_data_out, lanes(32'h70, 8));
        check("rmw_word_last", b_last_out, 0);

        // Reset with an undelivered word
        b_ready_in = 1'b0;
        idle();
        check("rpend_held", b_valid_out, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rpend_valid", b_valid_out, 0);
        check("rpend_data", b_data_out, 0);
        check("rpend_ready", f_ready_out, 1);
        b_ready_in = 1'b1;

        // Stale-lane check
        for (int i = 0; i < 8; i++) send(32'hFFFFFFFF, 1'b0);
        check("stale_full_data", b_data_out, {256{1'b1}});
        send(32'h1, 1'b1);
        check("stale_valid", b_valid_out, 1);
        check("stale_data", b_data_out, 256'h1);
        check("stale_last", b_last_out, 1);
`ifdef STREAM_PACK_KEEP_EN
        check("stale_keep", b_keep_out, 8'h01);
`endif
        idle();
        check("stale_delivered", b_valid_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
